mult_pipe: RTL and testbench
============================

MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, the operand beat is valid.
REQ-005 SHALL have port in_ready, output, 1, the block accepts an operand beat this cycle.
REQ-006 SHALL have port x, input, WIDTH, multiplicand.
REQ-007 SHALL have port y, input, WIDTH, multiplier.
REQ-008 SHALL have port is_signed, input, 1, per-beat mode: 1 = two's complement, 0 = unsigned.
REQ-009 SHALL have port out_valid, output, 1, the result beat is valid.
REQ-010 SHALL have port out_ready, input, 1, the consumer accepts the result this cycle.
REQ-011 SHALL have port o, output, 2*WIDTH, product.
REQ-012 SHALL have port busy, output, 1, asserted when any pipeline stage holds a valid beat.

Function
REQ-013 SHALL implement a 3-stage pipeline with stages S1, S2, S3, each holding a valid bit and data.
- S1: registers x, y, is_signed.
- S2: registers two carry-save rows, produced by AND partial products reduced with HA/FA cells.
- S3: registers the final sum, produced by a parallel-prefix (black/grey cell) adder; drives o.
REQ-014 Transfers SHALL follow the rules below.
- An input transfer occurs on an edge where in_valid=1 and in_ready=1.
- An output transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-015 SHALL give a latency of exactly 3 edges from input transfer to out_valid=1 when there is no backpressure; throughput SHALL be one beat per cycle.
REQ-016 Stage k SHALL load from stage k-1 when stage k is empty or stage k is being emptied in the same cycle, so bubbles collapse.
REQ-017 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; a combinational path from out_ready to in_ready is permitted.
REQ-018 While out_valid=1 and out_ready=0, o and out_valid SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-019 With is_signed=0, o SHALL equal x*y exactly (unsigned, 2*WIDTH bits).
REQ-020 With is_signed=1, o SHALL equal the exact two's-complement product (Baugh-Wooley sign handling); no overflow is possible.
REQ-021 is_signed SHALL travel with its beat; mixed-mode back-to-back beats SHALL each be computed in their own mode.
REQ-022 When out_valid=0, o SHALL hold its last value; it carries no meaning.
REQ-023 in_valid with in_ready=0 SHALL have no effect; the source must hold the beat.
REQ-024 A simultaneous input transfer into a full pipeline that is draining SHALL be accepted without loss.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear all stage valid bits, so out_valid=0 and busy=0, and SHALL set o to 0.
REQ-026 While rst_n=0, in_ready SHALL be 0.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 from the first edge onward.
REQ-028 Reset mid-operation SHALL discard all in-flight beats, and no stale result SHALL appear afterward.

Verification
REQ-029 WIDTH=8, unsigned 15*15 with out_ready=1 -> o=0x00E1 and out_valid=1 exactly 3 edges after acceptance, for 1 cycle.
REQ-030 WIDTH=8, signed beats, back-to-back at one beat per cycle:
- 0x80*0x80 -> 0x4000
- 0xFF*0x01 -> 0xFFFF
- 0x7F*0x80 -> 0xC080
Each result SHALL arrive on consecutive cycles in order.
REQ-031 WIDTH=8, same operands in both modes, 0xFF*0xFF: unsigned -> 0xFE01; signed -> 0x0001.
REQ-032 Backpressure test:
- Stimulus: 5 beats issued with out_ready=0 for 6 cycles, then out_ready=1.
- Required response: in_ready drops after 3 beats are accepted; o stays stable while stalled; all 5 results emerge in order with none dropped.
REQ-033 Reset test: rst_n pulsed low with 2 beats in flight -> out_valid=0 and o=0 immediately; no result appears afterward; a new beat 3*5 returns 0x000F.
REQ-034 Random test: 10k random operands in random mode, WIDTH in {4, 8, 16, 32}, with random in_valid/out_ready -> every result SHALL match a reference model, in order.

Source files
------------

// File: rtl/mult_pipe.sv
// Three-stage pipelined WIDTH x WIDTH multiplier with valid/ready handshaking.
// S1 registers operands, S2 a carry-save pair, S3 the prefix-adder sum.
module mult_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o,
  output logic               busy
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned Levels = $clog2(PW);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic             s1_signed_q, s1_signed_d;

  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_sum_q, s2_sum_d;
  logic [PW-1:0]    s2_carry_q, s2_carry_d;

  logic             s3_valid_q, s3_valid_d;
  logic [PW-1:0]    s3_prod_q, s3_prod_d;

  logic             s1_ready, s2_ready, s3_ready;

  logic [PW-1:0]    csa_s, csa_c, csa_t, pp_row;
  logic             pp_bit;
  logic [PW-1:0]    gen, prp, gen_nxt, prp_nxt, half_sum, pf_sum;

  // A stage may load when it is empty or its occupant leaves on this edge.
  always_comb begin
    s3_ready = !s3_valid_q || out_ready;
    s2_ready = !s2_valid_q || s3_ready;
    s1_ready = !s1_valid_q || s2_ready;
  end

  assign in_ready  = rst_n & s1_ready;
  assign out_valid = s3_valid_q;
  assign o         = s3_prod_q;
  assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

  // Partial products, Baugh-Wooley complemented in signed mode, reduced by 3:2 rows.
  always_comb begin
    csa_s  = '0;
    csa_c  = '0;
    csa_t  = '0;
    pp_row = '0;
    pp_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp_row = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
        pp_bit = s1_x_q[j] & s1_y_q[i];
        if (s1_signed_q && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
          pp_bit = ~pp_bit;
        end
        pp_row[i+j] = pp_bit;
      end
      csa_t = csa_s ^ csa_c ^ pp_row;
      csa_c = ((csa_s & csa_c) | (csa_s & pp_row) | (csa_c & pp_row)) << 1;
      csa_s = csa_t;
    end
    // Sign-correction constants: +2^WIDTH and +2^(2*WIDTH-1), modulo 2^(2*WIDTH).
    pp_row = '0;
    if (s1_signed_q) begin
      pp_row[WIDTH]  = 1'b1;
      pp_row[PW-1]   = 1'b1;
    end
    csa_t = csa_s ^ csa_c ^ pp_row;
    csa_c = ((csa_s & csa_c) | (csa_s & pp_row) | (csa_c & pp_row)) << 1;
    csa_s = csa_t;
    s2_sum_d   = csa_s;
    s2_carry_d = csa_c;
  end

  // Kogge-Stone prefix adder over the carry-save pair. Positions whose group already
  // reaches bit 0 act as grey cells: their propagate term is never consumed again.
  always_comb begin
    gen      = s2_sum_q & s2_carry_q;
    prp      = s2_sum_q ^ s2_carry_q;
    half_sum = prp;
    gen_nxt  = gen;
    prp_nxt  = prp;
    for (int l = 0; l < Levels; l++) begin
      gen_nxt = gen;
      prp_nxt = prp;
      for (int i = 0; i < PW; i++) begin
        if (i >= (1 << l)) begin
          gen_nxt[i] = gen[i] | (prp[i] & gen[i-(1<<l)]);
          prp_nxt[i] = prp[i] & prp[i-(1<<l)];
        end
      end
      gen = gen_nxt;
      prp = prp_nxt;
    end
    pf_sum = half_sum ^ {gen[PW-2:0], 1'b0};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_signed_d = s1_signed_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_x_d      = x;
        s1_y_d      = y;
        s1_signed_d = is_signed;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
    end
  end

  // o only changes when a real beat moves into S3, so it holds while idle or stalled.
  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_prod_d  = s3_prod_q;
    if (s3_ready) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_prod_d = pf_sum;
      end
    end
  end

  logic s2_load;
  assign s2_load = s2_ready & s1_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_signed_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_carry_q  <= '0;
      s3_valid_q  <= 1'b0;
      s3_prod_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_signed_q <= s1_signed_d;
      s2_valid_q  <= s2_valid_d;
      if (s2_load) begin
        s2_sum_q   <= s2_sum_d;
        s2_carry_q <= s2_carry_d;
      end
      s3_valid_q  <= s3_valid_d;
      s3_prod_q   <= s3_prod_d;
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboarded bench for mult_pipe: directed cases on the 8-bit instance, then random
// traffic on 4/8/16/32-bit instances checked against an arithmetic reference model.
module tb_mult_pipe;

  localparam int NInst   = 4;
  localparam int Dir     = 1;     // instance with WIDTH=8
  localparam int RandPer = 2500;  // 4 x 2500 = 10k random beats

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        iv   [NInst];
  logic        ir   [NInst];
  logic        sg   [NInst];
  logic        ov   [NInst];
  logic        ordy [NInst];
  logic        bz   [NInst];
  logic [31:0] xa   [NInst];
  logic [31:0] ya   [NInst];
  logic [63:0] oa   [NInst];

  for (genvar k = 0; k < NInst; k++) begin : g_dut
    localparam int unsigned W = 4 << k;
    logic [2*W-1:0] o_w;
    mult_pipe #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[k]),
      .in_ready  (ir[k]),
      .x         (xa[k][W-1:0]),
      .y         (ya[k][W-1:0]),
      .is_signed (sg[k]),
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .o         (o_w),
      .busy      (bz[k])
    );
    assign oa[k] = 64'(o_w);
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q [NInst][$];
  int          popped [NInst];
  int          sent   [NInst];
  int          base   [NInst];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Reference: operands as integers (two's complement when signed), product mod 2^(2w).
  function automatic logic [63:0] model(int w, logic [31:0] a, logic [31:0] b, bit s);
    longint      va, vb;
    logic [63:0] m;
    va = longint'({32'b0, a});
    vb = longint'({32'b0, b});
    if (s && a[w-1]) va = va - (longint'(1) << w);
    if (s && b[w-1]) vb = vb - (longint'(1) << w);
    m = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - 2 * w);
    return 64'(va * vb) & m;
  endfunction

  function automatic logic [31:0] rand_op(int w);
    logic [31:0] m;
    m = 32'hFFFF_FFFF >> (32 - w);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  function automatic bit queues_empty();
    for (int k = 0; k < NInst; k++) if (exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_sent();
    for (int k = 0; k < NInst; k++) if (sent[k] < RandPer) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, bit v, logic [31:0] a, logic [31:0] b, bit s);
    iv[k] = v;
    xa[k] = a;
    ya[k] = b;
    sg[k] = s;
  endtask

  // Stimulus side: an accepted beat pushes its expected product.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int k = 0; k < NInst; k++) begin
        if (iv[k] && ir[k]) exp_q[k].push_back(model(4 << k, xa[k], ya[k], sg[k]));
      end
    end
  end

  // Monitor: every output transfer pops and compares in order.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int k = 0; k < NInst; k++) begin
        if (ov[k] && ordy[k]) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            $display("FAIL w%0d unexpected result: got 0x%0h, expected no output",
                     4 << k, oa[k]);
          end else begin
            check($sformatf("w%0d result %0d", 4 << k, popped[k]), oa[k],
                  exp_q[k].pop_front());
            popped[k]++;
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0]  bx  [5] = '{8'h12, 8'h9C, 8'hFF, 8'h80, 8'h37};
    logic [7:0]  by  [5] = '{8'h34, 8'h7E, 8'h02, 8'hFF, 8'h80};
    bit          bs  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  sx  [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [7:0]  sy  [3] = '{8'h80, 8'h01, 8'h80};
    logic [63:0] se  [3] = '{64'h4000, 64'hFFFF, 64'hC080};
    int          n, p0, cnt;
    logic [63:0] held;
    bit          hold [NInst];

    for (int k = 0; k < NInst; k++) begin
      drive(k, 1'b0, 32'd0, 32'd0, 1'b0);
      ordy[k]   = 1'b1;
      popped[k] = 0;
      sent[k]   = 0;
      hold[k]   = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", 64'(ov[Dir]), 64'd0);
    check("reset busy", 64'(bz[Dir]), 64'd0);
    check("reset o", oa[Dir], 64'd0);
    check("reset in_ready", 64'(ir[Dir]), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("in_ready after reset", 64'(ir[Dir]), 64'd1);

    // 15*15 unsigned; the acceptance edge counts as the first of three edges.
    drive(Dir, 1'b1, 32'd15, 32'd15, 1'b0);
    tick();
    drive(Dir, 1'b0, 32'd0, 32'd0, 1'b0);
    check("latency edge1 out_valid", 64'(ov[Dir]), 64'd0);
    tick();
    check("latency edge2 out_valid", 64'(ov[Dir]), 64'd0);
    tick();
    check("latency edge3 out_valid", 64'(ov[Dir]), 64'd1);
    check("15*15 o", oa[Dir], 64'h00E1);
    tick();
    check("15*15 single cycle", 64'(ov[Dir]), 64'd0);

    // Signed back-to-back beats, one per cycle.
    for (int b = 0; b < 3; b++) begin
      drive(Dir, 1'b1, 32'(sx[b]), 32'(sy[b]), 1'b1);
      tick();
    end
    drive(Dir, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      check($sformatf("signed b2b %0d valid", b), 64'(ov[Dir]), 64'd1);
      check($sformatf("signed b2b %0d o", b), oa[Dir], se[b]);
      tick();
    end

    // Same operands in both modes.
    drive(Dir, 1'b1, 32'hFF, 32'hFF, 1'b0);
    tick();
    drive(Dir, 1'b1, 32'hFF, 32'hFF, 1'b1);
    tick();
    drive(Dir, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("FF*FF unsigned", oa[Dir], 64'hFE01);
    tick();
    check("FF*FF signed", oa[Dir], 64'h0001);
    tick();

    // Backpressure: 5 beats offered with out_ready low for 6 cycles.
    ordy[Dir] = 1'b0;
    n  = 0;
    p0 = popped[Dir];
    held = '0;
    for (int c = 0; c < 6; c++) begin
      if (n < 5) drive(Dir, 1'b1, 32'(bx[n]), 32'(by[n]), bs[n]);
      else drive(Dir, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      if (c == 3) begin
        check("stall beats accepted", 64'(n), 64'd3);
        check("stall in_ready", 64'(ir[Dir]), 64'd0);
        check("stall out_valid", 64'(ov[Dir]), 64'd1);
        held = oa[Dir];
      end
      if (c > 3) check($sformatf("stall o stable c%0d", c), oa[Dir], held);
      if (iv[Dir] && ir[Dir]) n++;
      tick();
    end
    ordy[Dir] = 1'b1;
    for (int g = 0; g < 50 && n < 5; g++) begin
      drive(Dir, 1'b1, 32'(bx[n]), 32'(by[n]), bs[n]);
      @(negedge clk);
      if (iv[Dir] && ir[Dir]) n++;
      tick();
    end
    drive(Dir, 1'b0, 32'd0, 32'd0, 1'b0);
    check("backpressure beats accepted", 64'(n), 64'd5);
    for (int g = 0; g < 20 && popped[Dir] - p0 < 5; g++) tick();
    check("backpressure results out", 64'(popped[Dir] - p0), 64'd5);

    // Reset with two beats in flight, the older one presenting at the output.
    ordy[Dir] = 1'b0;
    drive(Dir, 1'b1, 32'h21, 32'h43, 1'b0);
    tick();
    drive(Dir, 1'b1, 32'hF0, 32'h0F, 1'b1);
    tick();
    drive(Dir, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("pre-reset out_valid", 64'(ov[Dir]), 64'd1);
    #1 rst_n = 1'b0;
    exp_q[Dir].delete();
    #1;
    check("mid reset out_valid", 64'(ov[Dir]), 64'd0);
    check("mid reset o", oa[Dir], 64'd0);
    check("mid reset busy", 64'(bz[Dir]), 64'd0);
    check("mid reset in_ready", 64'(ir[Dir]), 64'd0);
    #1 rst_n = 1'b1;
    ordy[Dir] = 1'b1;
    cnt = 0;
    for (int g = 0; g < 6; g++) begin
      tick();
      if (ov[Dir]) cnt++;
    end
    check("no stale result after reset", 64'(cnt), 64'd0);
    drive(Dir, 1'b1, 32'd3, 32'd5, 1'b0);
    tick();
    drive(Dir, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    check("3*5 after reset valid", 64'(ov[Dir]), 64'd1);
    check("3*5 after reset o", oa[Dir], 64'h000F);
    tick();

    // Random traffic on every width with random valid and backpressure.
    for (int k = 0; k < NInst; k++) base[k] = popped[k];
    for (int g = 0; g < 40000 && !all_sent(); g++) begin
      for (int k = 0; k < NInst; k++) begin
        if (!hold[k]) begin
          if (sent[k] < RandPer && $urandom_range(0, 3) != 0)
            drive(k, 1'b1, rand_op(4 << k), rand_op(4 << k), 1'($urandom_range(0, 1)));
          else drive(k, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int k = 0; k < NInst; k++) begin
        if (iv[k] && ir[k]) begin
          sent[k]++;
          hold[k] = 1'b0;
        end else begin
          hold[k] = iv[k];
        end
      end
      tick();
    end
    for (int k = 0; k < NInst; k++) begin
      drive(k, 1'b0, 32'd0, 32'd0, 1'b0);
      ordy[k] = 1'b1;
    end
    for (int g = 0; g < 50 && !queues_empty(); g++) tick();
    tick();
    for (int k = 0; k < NInst; k++) begin
      check($sformatf("w%0d random beats sent", 4 << k), 64'(sent[k]), 64'(RandPer));
      check($sformatf("w%0d random results", 4 << k), 64'(popped[k] - base[k]),
            64'(sent[k]));
      check($sformatf("w%0d queue drained", 4 << k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
